// File: rtl/signal_monitor_multi_if.sv
// Sensor-side bus for signal_monitor_multi:
// two channels, mode/ack in; status, control and alarm out.
interface signal_monitor_multi_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] signal_a;
  logic [WIDTH-1:0] signal_b;
  logic [1:0]       mode_select;
  logic             alarm_ack;
  logic [2:0]       status_leds;
  logic [WIDTH-1:0] control_out;
  logic             alarm;
  logic [CNT_W-1:0] event_count;

  modport master (
    output signal_a,
    output signal_b,
    output mode_select,
    output alarm_ack,
    input  status_leds,
    input  control_out,
    input  alarm,
    input  event_count
  );

  modport slave (
    input  signal_a,
    input  signal_b,
    input  mode_select,
    input  alarm_ack,
    output status_leds,
    output control_out,
    output alarm,
    output event_count
  );
endinterface

// File: rtl/signal_monitor_multi.sv
// Two-channel signal monitor: compare/sum/ramp/watch modes,
// persistence-qualified alarm with ack and saturating event counter.
module signal_monitor_multi #(
  parameter int WIDTH  = 4,
  parameter int THRESH = 3,
  parameter int HOLD   = 4,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic reset,
  signal_monitor_multi_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ALARM = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] TH     = WIDTH'(THRESH);
  localparam logic [8:0]       HOLD_V = 9'(HOLD);
  localparam logic [CNT_W-1:0] CMAX   = '1;

  state_t           state, state_n;
  logic [7:0]       pcnt, pcnt_n;
  logic [WIDTH-1:0] ramp;
  logic [WIDTH-1:0] a, b, diff;
  logic [WIDTH:0]   sum;
  logic             over, watch;
  logic [WIDTH-1:0] ctrl_n, ctrl_q;
  logic [2:0]       leds_n, leds_q;
  logic [CNT_W-1:0] evt_q;

  assign a     = bus.signal_a;
  assign b     = bus.signal_b;
  assign diff  = (a > b) ? a - b : b - a;
  assign over  = diff > TH;
  assign watch = bus.mode_select == 2'b11;
  assign sum   = {1'b0, a} + {1'b0, b};

  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    case (state)
      IDLE: begin
        if (watch && over) begin
          pcnt_n  = 8'd1;
          state_n = (HOLD == 1) ? ALARM : ARMED;
        end else begin
          pcnt_n = 8'd0;
        end
      end
      ARMED: begin
        if (watch && over) begin
          if ({1'b0, pcnt} + 9'd1 == HOLD_V) begin
            state_n = ALARM;
            pcnt_n  = 8'd0;
          end else begin
            pcnt_n = pcnt + 8'd1;
          end
        end else begin
          state_n = IDLE;
          pcnt_n  = 8'd0;
        end
      end
      ALARM: begin
        // ack returns to IDLE only; re-qualification starts next edge
        if (bus.alarm_ack) begin
          state_n = IDLE;
          pcnt_n  = 8'd0;
        end
      end
      default: begin
        state_n = IDLE;
        pcnt_n  = 8'd0;
      end
    endcase
  end

  always_comb begin
    ctrl_n = '0;
    leds_n = 3'b000;
    unique case (bus.mode_select)
      2'b00: begin
        ctrl_n = (a > b) ? a : b;
        leds_n = {a > b, a == b, a < b};
      end
      2'b01: begin
        ctrl_n = sum[WIDTH-1:0];
        leds_n = {sum[WIDTH], sum[WIDTH-1:0] == '0, sum[WIDTH-1]};
      end
      2'b10: begin
        ctrl_n = ramp;
        leds_n = {&ramp, ramp == '0, ramp[0]};
      end
      2'b11: begin
        ctrl_n = diff;
        leds_n = {state_n == ALARM, state_n == ARMED, over};
      end
      default: begin
        ctrl_n = '0;
        leds_n = 3'b000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pcnt   <= 8'd0;
      ramp   <= '0;
      ctrl_q <= '0;
      leds_q <= 3'b000;
      evt_q  <= '0;
    end else begin
      state  <= state_n;
      pcnt   <= pcnt_n;
      ramp   <= (bus.mode_select == 2'b10) ? ramp + WIDTH'(1) : '0;
      ctrl_q <= ctrl_n;
      leds_q <= leds_n;
      if (state != ALARM && state_n == ALARM && evt_q != CMAX)
        evt_q <= evt_q + CNT_W'(1);
    end
  end

  assign bus.status_leds = leds_q;
  assign bus.control_out = ctrl_q;
  assign bus.alarm       = (state == ALARM);
  assign bus.event_count = evt_q;

endmodule

// File: doc/signal_monitor_multi.md
# signal_monitor_multi

Parametrised next-generation signal monitor. It compares two WIDTH-bit input channels under a 2-bit mode select and drives registered status LEDs and a WIDTH-bit control word. It adds a persistence-qualified alarm state machine with acknowledge, a ramp generator mode, and a saturating alarm-event counter. It sits between the sensor input registers and the panel/actuator outputs.

## Interface
- WIDTH, 4, bit width of signal_a, signal_b, control_out
- THRESH, 3, over-limit threshold: over = (|a-b| > THRESH); must fit in WIDTH bits
- HOLD, 4, consecutive over cycles required to raise alarm; legal range 1..255
- CNT_W, 8, width of event_count
- clk  input  1  single clock, rising-edge
- reset  input  1  asynchronous, active-low (0 = reset asserted)
- signal_a  input  WIDTH  channel A, unsigned
- signal_b  input  WIDTH  channel B, unsigned
- mode_select  input  2  00 COMPARE, 01 SUM, 10 RAMP, 11 WATCH
- alarm_ack  input  1  level-sampled acknowledge; clears a latched alarm
- status_leds  output  3  mode-dependent status flags, registered
- control_out  output  WIDTH  mode-dependent result, registered
- alarm  output  1  high while the FSM is in ALARM
- event_count  output  CNT_W  number of IDLE/ARMED→ALARM entries, saturating

## Operation
- All inputs are sampled on the rising clk edge. All outputs are registered. Latency from input to output is 1 edge.
- diff = |signal_a − signal_b|, WIDTH bits unsigned. over = diff > THRESH, strict.
- COMPARE (00): control_out = max(a,b); status_leds = {a>b, a==b, a<b}.
- SUM (01): control_out = (a+b) mod 2^WIDTH; status_leds = {carry-out, truncated sum==0, truncated sum MSB}.
- RAMP (10): internal ramp register, cleared every cycle mode≠10. In mode 10: control_out = ramp, then ramp = ramp+1, wrapping all-ones→0. status_leds = {ramp==all-ones, ramp==0, ramp[0]}, using the value being output.
- WATCH (11): control_out = diff; status_leds = {alarm next-state==ALARM, next-state==ARMED, over}.
- Alarm FSM, states IDLE, ARMED, ALARM, with a persistence counter pcnt (8 bits):
  - IDLE: mode 11 and over → pcnt=1; if HOLD==1 go to ALARM, else go to ARMED. Otherwise stay, pcnt=0.
  - ARMED: mode 11 and over → if pcnt+1==HOLD go to ALARM, else pcnt=pcnt+1. Not over, or mode≠11 → IDLE, pcnt=0.
  - ALARM: held in every mode until alarm_ack=1 is sampled → IDLE, pcnt=0. No re-arm happens on the ack edge, even if over=1; qualification restarts on the next edge.
- event_count increments on every entry into ALARM. It holds at 2^CNT_W−1. It is cleared only by reset.
- alarm = (state==ALARM), registered.

## Timing
- Reset asserted (reset=0): state IDLE, pcnt=0, ramp=0. status_leds=000, control_out=0, alarm=0, event_count=0. All take effect immediately, with no clock edge needed.
- Reset mid-operation (ARMED/ALARM/RAMP) discards all state asynchronously. The first edge after release behaves as if from IDLE with ramp=0.
- Alarm latency: after the HOLD-th consecutive edge sampling mode=11 and over=1, alarm is high. With HOLD=4, alarm rises after edge 4.
- A single non-over sample, or a mode change, while ARMED restarts the qualification.
- alarm_ack while not in ALARM has no effect.
- A mode change takes effect on the next edge; there is no pipeline flush beyond the 1-edge latency.
- RAMP wraps: 2^WIDTH−1 is followed by 0.

## Test plan
- Reset/COMPARE: hold reset=0 with a=7, b=3 → all outputs 0. Release, mode=00 → after 1 edge control_out=7, status_leds=100. Then a=3, b=9 → control_out=9, status_leds=001.
- SUM: mode=01, a=12, b=5 → control_out=1, status_leds=100. Then a=8, b=8 → control_out=0, status_leds=110.
- RAMP: mode=10 for 20 edges, WIDTH=4 → control_out 0,1,…,15,0,1,2,3. status_leds[2]=1 only on 15; status_leds[1]=1 on 0. Leave mode and return → restarts at 0.
- WATCH alarm: mode=11, a=10, b=6 (diff 4 > 3) for 4 edges → control_out=4, alarm rises after edge 4, event_count=1. Then set a=b → alarm stays 1. Pulse alarm_ack for 1 edge → alarm=0 after that edge.
- Persistence: diff=4 for 3 edges, then diff=0 for 1 edge, then diff=4 for 3 edges → alarm never rises, event_count=0. diff=3 for 10 edges → status_leds[0]=0, no arming.
- Async reset and saturation: CNT_W=2, 4 full alarm/ack cycles → event_count=3 (saturated). Drop reset between edges while in ALARM → alarm and event_count go to 0 before the next edge.
